line_fill_responder: RTL and testbench
======================================

// Module: line_fill_responder
// PURPOSE
// Memory-side responder for the data-cache line-fill interface. Accepts one line request at a time from the set-associative cache.
// Read: returns LINE_SIZE words as a burst after a programmable latency. Write (victim writeback): absorbs LINE_SIZE words.
// Sits between the data cache and the backing word RAM; replaces the cache's direct combinational whole-line read.
// PARAMETERS
// DATA_WIDTH    32    word width
// ADDR_WIDTH    32    word address width (word-addressed, as the cache's Addr)
// LINE_SIZE     4     words per line; power of 2, >=2
// MEM_DEPTH     1024  backing RAM depth in words; power of 2, multiple of LINE_SIZE
// READ_LATENCY  3     cycles from request accept to first read beat; 1..15
// PORTS
// clk         in   1           clock; all logic on posedge
// rst         in   1           synchronous reset, active-high
// req_valid   in   1           cache presents a line request
// req_ready   out  1           responder idle, request accepted when req_valid&req_ready
// req_write   in   1           1 = writeback line, 0 = fill line
// req_addr    in   ADDR_WIDTH  word address; low $clog2(LINE_SIZE) bits ignored
// wr_valid    in   1           writeback beat valid
// wr_ready    out  1           responder accepts writeback beat
// wr_data     in   DATA_WIDTH  writeback beat data
// wr_done     out  1           1-cycle pulse: whole line written
// rd_valid    out  1           fill beat valid
// rd_ready    in   1           cache accepts fill beat
// rd_data     out  DATA_WIDTH  fill beat data
// rd_last     out  1           marks final beat of fill (beat LINE_SIZE-1)
// BEHAVIOUR
// - Reset (rst=1 at posedge): state IDLE; req_ready=1; wr_ready=0, wr_done=0, rd_valid=0, rd_last=0, rd_data=0; counters 0.
// - RAM contents are not cleared by reset; sim init to 0. Reset mid-burst aborts the burst; partial writeback words already written stay.
// - FSM: IDLE -> (accept, write) WR_BEAT | (accept, read) WAIT -> RD_BEAT -> IDLE; WR_BEAT -> DONE -> IDLE.
// - IDLE: req_ready=1. On accept, latch line base = {req_addr[ADDR_WIDTH-1:log2(LINE_SIZE)], 0} mod MEM_DEPTH and req_write.
// - WAIT: counter loads READ_LATENCY-1 at accept, decrements each cycle; leaves at 0. First rd_valid is exactly READ_LATENCY cycles after accept.
// - RD_BEAT: rd_data = RAM[base+beat]; beat advances only on rd_valid&rd_ready. rd_data/rd_last held stable while rd_ready=0.
// - RD_BEAT: rd_last=1 iff beat==LINE_SIZE-1; after that handshake -> IDLE, rd_valid=0 next cycle.
// - WR_BEAT: wr_ready=1; on wr_valid&wr_ready write RAM[base+beat]<=wr_data, beat++. After beat LINE_SIZE-1 -> DONE.
// - DONE: wr_done=1 for exactly one cycle, wr_ready=0, then IDLE. A new request is accepted no earlier than the following cycle.
// - Beats strictly in order 0..LINE_SIZE-1, no critical-word-first. Beat counter width log2(LINE_SIZE), wraps to 0 at line end.
// - Address wrap: line base taken modulo MEM_DEPTH; no error for out-of-range addresses.
// - req_ready=0 in every non-IDLE state; req_valid held by the cache meanwhile is ignored, not queued.
// - wr_valid outside WR_BEAT is ignored; rd_ready outside RD_BEAT is ignored.
// - Read-after-write to the same line in back-to-back requests returns the newly written data.
// STRUCTURE
// - Package cache_mem_pkg: resp_state_e {IDLE,WAIT,RD_BEAT,WR_BEAT,DONE}; localparams OFFSET_BITS=$clog2(LINE_SIZE), MEM_AW=$clog2(MEM_DEPTH).
// - Package cache_mem_pkg: line_req_t struct {write, base}; shared with the cache for its request side.
// - Sub-module mem_word_ram: single-port, synchronous write, combinational read, DATA_WIDTH x MEM_DEPTH.
// - Top holds FSM, latency counter and beat counter.
// TESTING
// 1 Reset: rst=1 2 cycles -> req_ready=1, rd_valid=0, wr_ready=0, wr_done=0.
// 2 Writeback line addr 0x40, beats A0..A3 with no gaps -> wr_ready 4 cycles, wr_done pulses once, RAM[0x40..0x43]=A0..A3.
// 3 Fill 0x40, rd_ready=1, READ_LATENCY=3 -> rd_valid 3 cycles after accept; data A0..A3; rd_last only on A3.
// 4 Fill 0x42 with rd_ready toggled 1,0,0,1,1,0,1 -> same base 0x40 data, no beat lost or repeated; rd_data stable while stalled.
// 5 req_valid held through a burst -> second request accepted exactly one cycle after return to IDLE; addr 0x1000+MEM_DEPTH wraps to 0x1000.
// 6 rst asserted after beat 1 of a writeback -> IDLE next cycle; RAM holds beats 0-1 only; a following fill returns them.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// rtl/cache_mem_pkg.sv - shared types and default geometry for the cache line-fill interface
package cache_mem_pkg;

  localparam int LINE_WORDS  = 4;
  localparam int RAM_WORDS   = 1024;
  localparam int OFFSET_BITS = $clog2(LINE_WORDS);
  localparam int MEM_AW      = $clog2(RAM_WORDS);
  localparam int LINE_ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_BEAT,
    WR_BEAT,
    DONE
  } resp_state_e;

  typedef struct packed {
    logic                   write;
    logic [LINE_ADDR_W-1:0] base;
  } line_req_t;

endpackage

// File: rtl/mem_word_ram.sv
// rtl/mem_word_ram.sv - single-port word RAM, synchronous write, combinational read
module mem_word_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int AW         = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/line_fill_responder.sv
// rtl/line_fill_responder.sv - memory-side line responder: delayed fill bursts and victim writebacks
module line_fill_responder
  import cache_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = LINE_ADDR_W,
  parameter int LINE_SIZE    = LINE_WORDS,
  parameter int MEM_DEPTH    = RAM_WORDS,
  parameter int READ_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_done,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last
);

  localparam int OFF_W = $clog2(LINE_SIZE);
  localparam int RAM_AW = $clog2(MEM_DEPTH);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_SIZE - 1);

  resp_state_e           state_q, state_d;
  logic [3:0]            lat_q, lat_d;
  logic [OFF_W-1:0]      beat_q, beat_d;
  line_req_t             req_q, req_d;
  logic                  ram_we;
  logic [RAM_AW-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Line base is aligned, so the beat index simply fills the offset bits.
  assign ram_addr = {req_q.base[RAM_AW-1:OFF_W], beat_q};

  mem_word_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (RAM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wr_data),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    beat_d    = beat_q;
    req_d     = req_q;
    ram_we    = 1'b0;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    wr_done   = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    rd_data   = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d.write = req_write;
          req_d.base  = LINE_ADDR_W'({req_addr[RAM_AW-1:OFF_W], {OFF_W{1'b0}}});
          beat_d      = '0;
          if (req_write) begin
            state_d = WR_BEAT;
          end else begin
            state_d = WAIT;
            lat_d   = 4'(READ_LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (lat_q == 4'd0) begin
          state_d = RD_BEAT;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RD_BEAT: begin
        rd_valid = 1'b1;
        rd_data  = ram_rdata;
        rd_last  = (beat_q == LAST_BEAT);
        if (rd_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      WR_BEAT: begin
        wr_ready = 1'b1;
        // A reset landing on a beat must not commit that beat.
        if (wr_valid && !rst) begin
          ram_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        wr_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= 4'd0;
      beat_q  <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      req_q   <= req_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{req_addr, req_q.write, req_q.base};

endmodule

// File: tb/tb_line_fill_responder.sv
// tb/tb_line_fill_responder.sv - table-driven bench for line_fill_responder
module tb_line_fill_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic        wr_valid, wr_ready, wr_done;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;

  int pass_cnt = 0;
  int total    = 0;

  typedef logic [3:0][31:0] line_t;
  typedef struct {
    logic        write;
    logic [31:0] addr;
    line_t       data;
  } vec_t;

  vec_t  tbl [8];
  line_t la, lb, lc, ld, le, lmix;

  always #5 clk = ~clk;

  line_fill_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .LINE_SIZE(4), .MEM_DEPTH(1024), .READ_LATENCY(3)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic line_t mk_line(input logic [31:0] seed);
    line_t l;
    for (int i = 0; i < 4; i++) l[i] = seed + 32'(i);
    return l;
  endfunction

  task automatic start_req(input logic wr, input logic [31:0] addr);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    step();
  endtask

  task automatic writeback(input logic [31:0] addr, input line_t d, input string tag);
    int wr_cnt = 0;
    start_req(1'b1, addr);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wr_ready) wr_cnt++;
      wr_valid = 1'b1;
      wr_data  = d[i];
      step();
    end
    wr_valid = 1'b0;
    check({tag, "_wr_ready_cycles"}, wr_cnt, 4);
    check({tag, "_wr_done_pulse"}, wr_done, 1);
    check({tag, "_wr_ready_in_done"}, wr_ready, 0);
    check({tag, "_req_ready_in_done"}, req_ready, 0);
    step();
    check({tag, "_wr_done_cleared"}, wr_done, 0);
    check({tag, "_idle_after_done"}, req_ready, 1);
  endtask

  // Called one cycle after the accepting edge.
  task automatic collect_fill(input line_t exp, input logic [15:0] pat, input int plen,
                              input string tag);
    int          n = 0;
    int          beat = 0;
    int          cyc = 0;
    int          pi = 0;
    logic        stalled = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;
    while (!rd_valid && n < 20) begin
      check({tag, "_req_ready_busy"}, req_ready, 0);
      step();
      n++;
    end
    check({tag, "_latency"}, n, 3);
    while (beat < 4 && cyc < 40) begin
      rd_ready = (pi < plen) ? pat[pi] : 1'b1;
      pi++;
      check({tag, "_rd_valid_held"}, rd_valid, 1);
      check({tag, "_req_ready_burst"}, req_ready, 0);
      if (stalled) begin
        check({tag, "_stall_data_stable"}, rd_data, held_data);
        check({tag, "_stall_last_stable"}, rd_last, held_last);
      end
      if (rd_valid) begin
        check($sformatf("%s_rd_last_beat%0d", tag, beat), rd_last, (beat == 3));
        if (rd_ready) begin
          check($sformatf("%s_data_beat%0d", tag, beat), rd_data, exp[beat]);
          beat++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held_data = rd_data;
          held_last = rd_last;
        end
      end
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    check({tag, "_beats_seen"}, beat, 4);
    check({tag, "_rd_valid_after_last"}, rd_valid, 0);
    check({tag, "_idle_after_fill"}, req_ready, 1);
  endtask

  task automatic fill(input logic [31:0] addr, input line_t exp, input logic [15:0] pat,
                      input int plen, input string tag);
    start_req(1'b0, addr);
    req_valid = 1'b0;
    collect_fill(exp, pat, plen, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    la = mk_line(32'hA0A0_0000);
    lb = mk_line(32'hB0B0_0000);
    lc = mk_line(32'hC0C0_0000);
    ld = mk_line(32'hD0D0_0000);
    le = mk_line(32'hE0E0_0000);
    lmix = {le[3], le[2], ld[1], ld[0]};

    tbl[0] = '{1'b1, 32'h0000_0040, la};
    tbl[1] = '{1'b0, 32'h0000_0040, la};
    tbl[2] = '{1'b1, 32'h0000_1400, lb};
    tbl[3] = '{1'b0, 32'h0000_1000, lb};
    tbl[4] = '{1'b0, 32'h0000_0003, lb};
    tbl[5] = '{1'b1, 32'h0000_03FC, lc};
    tbl[6] = '{1'b0, 32'h0000_07FE, lc};
    tbl[7] = '{1'b1, 32'h0000_0080, le};

    step();
    step();
    rst = 1'b0;
    check("reset_req_ready", req_ready, 1);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_wr_ready", wr_ready, 0);
    check("reset_wr_done", wr_done, 0);
    check("reset_rd_last", rd_last, 0);
    check("reset_rd_data", rd_data, 0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].write) writeback(tbl[i].addr, tbl[i].data, $sformatf("vec%0d_wb", i));
      else fill(tbl[i].addr, tbl[i].data, 16'hFFFF, 0, $sformatf("vec%0d_fill", i));
    end

    // Fill at a mid-line address with backpressure 1,0,0,1,1,0,1.
    fill(32'h0000_0042, la, 16'b0000_0000_0101_1001, 7, "stall_fill");

    // Request held high through a burst; the next one lands one cycle after IDLE.
    start_req(1'b0, 32'h0000_0040);
    req_addr = 32'h0000_1000 + 32'd1024;
    collect_fill(la, 16'hFFFF, 0, "held_first");
    step();
    check("held_second_accepted", req_ready, 0);
    req_valid = 1'b0;
    collect_fill(lb, 16'hFFFF, 0, "held_second");

    // Reset after beat 1 of a writeback, with beat 2 presented during reset.
    start_req(1'b1, 32'h0000_0080);
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = ld[i];
      step();
    end
    rst     = 1'b1;
    wr_data = ld[2];
    step();
    rst      = 1'b0;
    wr_valid = 1'b0;
    check("abort_req_ready", req_ready, 1);
    check("abort_wr_ready", wr_ready, 0);
    check("abort_wr_done", wr_done, 0);
    fill(32'h0000_0080, lmix, 16'hFFFF, 0, "abort_fill");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
